// File: rtl/datareg_write_arbiter.sv
// Round-robin write arbiter/sequencer feeding the shared data register:
// grants one requester, pulses the register load enable, then acknowledges the winner.
module datareg_write_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic                    reg_en,
  output logic [DATA_W-1:0]       reg_din,
  output logic [N_REQ-1:0]        ack,
  output logic [1:0]              gnt_id,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          gnt_id_q, gnt_id_d;
  logic                reg_en_q, reg_en_d;
  logic [DATA_W-1:0]   reg_din_q, reg_din_d;
  logic [N_REQ-1:0]    ack_q, ack_d;

  logic                found;
  logic [1:0]          win;
  logic [DATA_W-1:0]   win_data;
  int unsigned         idx;
  int unsigned         ptr_nxt;

  // First set request scanning upward from ptr, wrapping modulo N_REQ.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    idx      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr_q) + i) % N_REQ;
      if (!found && req[idx[1:0]]) begin
        found    = 1'b1;
        win      = idx[1:0];
        win_data = wdata[idx*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    reg_din_d = reg_din_q;
    reg_en_d  = 1'b0;
    ack_d     = '0;
    ptr_nxt   = (32'(gnt_id_q) + 1) % N_REQ;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_id_d  = win;
          reg_din_d = win_data;
          reg_en_d  = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        ack_d[gnt_id_q] = 1'b1;
        state_d         = ACK;
      end
      ACK: begin
        ptr_d   = ptr_nxt[1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_id_q  <= '0;
      reg_en_q  <= 1'b0;
      reg_din_q <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
      reg_en_q  <= reg_en_d;
      reg_din_q <= reg_din_d;
      ack_q     <= ack_d;
    end
  end

  assign reg_en  = reg_en_q;
  assign reg_din = reg_din_q;
  assign ack     = ack_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_datareg_write_arbiter.sv
// Self-checking bench for datareg_write_arbiter: directed scenarios plus randomized
// requests checked against a round-robin reference model.
module tb_datareg_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [55:0] wdata;
  logic        reg_en;
  logic [13:0] reg_din;
  logic [3:0]  ack;
  logic [1:0]  gnt_id;
  logic        busy;

  int          n_cmp;
  int          n_err;
  int          m_ptr;
  logic [13:0] m_din;

  datareg_write_arbiter #(.N_REQ(4), .DATA_W(14)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wdata   (wdata),
    .reg_en  (reg_en),
    .reg_din (reg_din),
    .ack     (ack),
    .gnt_id  (gnt_id),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Round-robin rule: first requesting index found scanning up from p, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (p + k) % 4;
      if (r[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [13:0] lane(input logic [55:0] wd, input int i);
    return wd[i*14 +: 14];
  endfunction

  // Expected observation of a full grant: {en,din,gnt,busy,ack} at E0+, {en,ack,busy}
  // at E1+, {busy,ack,en} at E2+.
  function automatic logic [33:0] exp_obs(input int w, input logic [13:0] d);
    logic [1:0] g;
    logic [3:0] oh;
    g  = w[1:0];
    oh = 4'b0001 << g;
    return {1'b1, d, g, 1'b1, 4'b0000, 1'b0, oh, 1'b1, 1'b0, 4'b0000, 1'b0};
  endfunction

  // Drives one request at a negedge and records the three following output samples;
  // the acknowledged requester drops its req when it sees ack.
  task automatic run_grant(input logic [3:0] r, input logic [55:0] wd,
                           output logic [33:0] obs);
    req   = r;
    wdata = wd;
    @(negedge clk);
    obs[33]    = reg_en;
    obs[32:19] = reg_din;
    obs[18:17] = gnt_id;
    obs[16]    = busy;
    obs[15:12] = ack;
    @(negedge clk);
    obs[11]    = reg_en;
    obs[10:7]  = ack;
    obs[6]     = busy;
    req        = req & ~ack;
    @(negedge clk);
    obs[5]     = busy;
    obs[4:1]   = ack;
    obs[0]     = reg_en;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({reg_en, reg_din, ack, gnt_id, busy} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", {reg_en, reg_din, ack, gnt_id, busy}, 22'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    m_ptr = 0;
  endtask

  task automatic test_single();
    logic [33:0] obs;
    run_grant(4'b0001, {42'd0, 14'h3FFF}, obs);
    n_cmp++;
    if (obs !== exp_obs(0, 14'h3FFF)) begin
      n_err++;
      $display("FAIL single_grant: got %h want %h", obs, exp_obs(0, 14'h3FFF));
    end
    m_ptr = 1;
  endtask

  task automatic test_all_simultaneous();
    logic [33:0] obs;
    logic [55:0] wd;
    do_reset();
    for (int i = 0; i < 4; i++) wd[i*14 +: 14] = 14'(100 + i);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      run_grant(req, wd, obs);
      n_cmp++;
      if (obs !== exp_obs(i, 14'(100 + i))) begin
        n_err++;
        $display("FAIL all_req_grant%0d: got %h want %h", i, obs, exp_obs(i, 14'(100 + i)));
      end
    end
    m_ptr = 0;
  endtask

  task automatic test_fairness();
    logic [33:0] obs;
    logic [55:0] wd;
    int          w;
    wd  = {14'h0333, 14'h0222, 14'h0111, 14'h0000};
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w = (i % 2 == 0) ? 0 : 2;
      run_grant(req | 4'b0101, wd, obs);
      n_cmp++;
      if (obs !== exp_obs(w, lane(wd, w))) begin
        n_err++;
        $display("FAIL fairness%0d: got %h want %h", i, obs, exp_obs(w, lane(wd, w)));
      end
    end
    req   = 4'b0000;
    m_ptr = 3;
  endtask

  task automatic test_wraparound();
    logic [33:0] obs;
    logic [55:0] wd;
    wd = {14'h1D03, 14'h1D02, 14'h1D01, 14'h1D00};
    run_grant(4'b1000, wd, obs);
    n_cmp++;
    if (obs !== exp_obs(3, 14'h1D03)) begin
      n_err++;
      $display("FAIL wrap_grant3: got %h want %h", obs, exp_obs(3, 14'h1D03));
    end
    run_grant(4'b1001, wd, obs);
    n_cmp++;
    if (obs !== exp_obs(0, 14'h1D00)) begin
      n_err++;
      $display("FAIL wrap_ptr0: got %h want %h", obs, exp_obs(0, 14'h1D00));
    end
    run_grant(req | 4'b0001, wd, obs);
    n_cmp++;
    if (obs !== exp_obs(3, 14'h1D03)) begin
      n_err++;
      $display("FAIL wrap_ptr1: got %h want %h", obs, exp_obs(3, 14'h1D03));
    end
    req   = '0;
    m_ptr = 0;
  endtask

  task automatic test_reset_mid_op();
    logic [33:0] obs;
    logic [3:0]  seen_ack;
    logic [55:0] wd;
    do_reset();
    wd    = {14'h0AAA, 14'h0BBB, 14'h0CCC, 14'h0DDD};
    req   = 4'b0001;
    wdata = wd;
    @(negedge clk);
    n_cmp++;
    if (reg_en !== 1'b1) begin
      n_err++;
      $display("FAIL midwrite_en_before: got %b want 1", reg_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({reg_en, reg_din, ack, gnt_id, busy} !== 22'd0) begin
      n_err++;
      $display("FAIL midwrite_async: got %h want %h", {reg_en, reg_din, ack, gnt_id, busy}, 22'd0);
    end
    req = '0;
    @(negedge clk);
    rst_n    = 1'b1;
    seen_ack = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen_ack = seen_ack | ack;
    end
    n_cmp++;
    if (seen_ack !== 4'b0000) begin
      n_err++;
      $display("FAIL midwrite_no_ack: got %b want 0000", seen_ack);
    end
    m_ptr = 0;
    run_grant(4'b0100, wd, obs);
    n_cmp++;
    if (obs !== exp_obs(2, 14'h0BBB)) begin
      n_err++;
      $display("FAIL after_reset_grant2: got %h want %h", obs, exp_obs(2, 14'h0BBB));
    end
    run_grant(4'b1011, wd, obs);
    n_cmp++;
    if (obs !== exp_obs(3, 14'h0AAA)) begin
      n_err++;
      $display("FAIL after_reset_ptr3: got %h want %h", obs, exp_obs(3, 14'h0AAA));
    end
    // Reset while in ACK.
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack, busy} !== 5'd0) begin
      n_err++;
      $display("FAIL midack_async: got %h want %h", {ack, busy}, 5'd0);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_ptr = 0;
  endtask

  task automatic test_data_change_busy();
    logic [33:0] obs;
    req   = 4'b0001;
    wdata = {42'd0, 14'h0123};
    @(negedge clk);
    wdata[13:0] = 14'h0456;
    n_cmp++;
    if (reg_din !== 14'h0123) begin
      n_err++;
      $display("FAIL busy_din_write: got %h want 0123", reg_din);
    end
    @(negedge clk);
    n_cmp++;
    if ({reg_din, ack} !== {14'h0123, 4'b0001}) begin
      n_err++;
      $display("FAIL busy_din_ack: got %h want %h", {reg_din, ack}, {14'h0123, 4'b0001});
    end
    req = '0;
    @(negedge clk);
    m_ptr = 1;
    run_grant(4'b0001, wdata, obs);
    n_cmp++;
    if (obs !== exp_obs(0, 14'h0456)) begin
      n_err++;
      $display("FAIL busy_later_write: got %h want %h", obs, exp_obs(0, 14'h0456));
    end
    m_ptr = 1;
    m_din = 14'h0456;
  endtask

  task automatic test_random();
    logic [33:0] obs;
    logic [63:0] rnd;
    logic [3:0]  r;
    int          w;
    for (int n = 0; n < 40; n++) begin
      r   = 4'($urandom_range(0, 15));
      rnd = {$urandom(), $urandom()};
      if (r == 4'b0000) begin
        req   = '0;
        wdata = rnd[55:0];
        @(negedge clk);
        n_cmp++;
        if ({reg_en, busy, ack, reg_din} !== {1'b0, 1'b0, 4'b0000, m_din}) begin
          n_err++;
          $display("FAIL rand_idle%0d: got %h want %h", n, {reg_en, busy, ack, reg_din},
                   {1'b0, 1'b0, 4'b0000, m_din});
        end
      end else begin
        w = pick(r, m_ptr);
        run_grant(r, rnd[55:0], obs);
        n_cmp++;
        if (obs !== exp_obs(w, lane(rnd[55:0], w))) begin
          n_err++;
          $display("FAIL rand_grant%0d: got %h want %h", n, obs, exp_obs(w, lane(rnd[55:0], w)));
        end
        m_ptr = (w + 1) % 4;
        m_din = lane(rnd[55:0], w);
      end
    end
    req = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_ptr = 0;
    m_din = '0;
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    test_reset();
    test_single();
    test_all_simultaneous();
    test_fairness();
    test_wraparound();
    test_reset_mid_op();
    test_data_change_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
